flash_arbiter: RTL and testbench
================================

# flash_arbiter

Two-port sequencer for the 32K-word × 16 external flash bus (15-bit word address, 16-bit bidirectional data, active-low CE/OE/WE). Accepts read/write requests from two independent requesters (port A, e.g. CPU PRG fetch; port B, e.g. PPU CHR fetch or loader), arbitrates round-robin, and generates the flash strobe waveforms with programmable wait states. Sits between the mapper logic and the board-level flash pins, or the flash simulation model.

## Interface
- RD_WAIT, 2: cycles `flash_oe_n` is held low before read data is sampled; legal range 1..15.
- WR_WAIT, 2: cycles `flash_we_n` is held low; legal range 1..15.

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request, level; held until `a_ack`
- a_we  in  1  port A: 1 = write, 0 = read; stable while `a_req`
- a_addr  in  15  port A word address
- a_wdata  in  16  port A write data
- a_rdata  out  16  port A read data, registered
- a_ack  out  1  port A completion pulse, one cycle
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: port B, identical to port A
- flash_address  out  15  flash word address, registered
- flash_ce_n  out  1  chip enable
- flash_oe_n  out  1  output enable
- flash_we_n  out  1  write enable
- flash_data  inout  16  driven only in WRITE/HOLD, else high-Z

## Operation
- States: IDLE, SETUP, READ, WRITE, HOLD, DONE.
- IDLE: CE/OE/WE high, bus Z. If any req is high, grant one port. Latch its addr, we and wdata into holding registers; drive `flash_address`; go to SETUP.
- Arbitration: if only one port requests, grant it. If both request, grant the port not granted last. `last_grant` resets to B, so A wins the first contention.
- SETUP (1 cycle): `flash_ce_n`=0, address stable. Next state is WRITE if the latched we is 1, else READ.
- READ (RD_WAIT cycles): `flash_ce_n`=0, `flash_oe_n`=0. On the last cycle's edge, capture `flash_data` into the granted port's rdata; go to DONE.
- WRITE (WR_WAIT cycles): `flash_ce_n`=0, `flash_we_n`=0, bus driven with latched wdata; then go to HOLD.
- HOLD (1 cycle): `flash_we_n`=1, `flash_ce_n`=0, bus still driven (data hold after WE rise); then go to DONE.
- DONE (1 cycle): CE/OE/WE high, bus Z. Granted port's ack=1. Update `last_grant`; go to IDLE.
- Handshake: the requester drops req on the edge where it sees ack=1. If req is still high in the following IDLE cycle, that is a new back-to-back request.
- The non-granted port's req is ignored until IDLE; its rdata is untouched.
- rdata of each port holds its last read value until that port's next read completes.
- Wait counter is 4 bits and is loaded with RD_WAIT-1 or WR_WAIT-1 on entry to READ/WRITE.
- Address, we and wdata changes from a requester after the grant have no effect on the transaction in progress.

## Timing
- Reset values: `flash_ce_n`=`flash_oe_n`=`flash_we_n`=1, `flash_address`=0, bus Z, `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, state IDLE, `last_grant`=B.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). No ack is issued for the aborted transaction.
- Cycle 0 = IDLE cycle in which req is sampled high.
- Read: SETUP in cycle 1, READ in cycles 2..1+RD_WAIT, ack and rdata valid in cycle 2+RD_WAIT (cycle 4 with defaults).
- Write: SETUP in cycle 1, WE low in cycles 2..1+WR_WAIT, HOLD in cycle 2+WR_WAIT, ack in cycle 3+WR_WAIT (cycle 5 with defaults).
- Minimum spacing between transactions: one IDLE cycle after DONE. CE is high for at least two consecutive cycles (DONE + IDLE).
- OE and WE are never low in the same cycle.
- The bus is never driven while OE is low.

## Configuration
- FLASH_WRITE_EN defined: write path as described above.
- FLASH_WRITE_EN undefined: WRITE and HOLD states are not compiled. `flash_we_n` is tied to 1 and the bus is never driven. A write request goes SETUP→DONE and is acked in cycle 2; flash contents are unchanged.

## Test plan
- Single read, A: flash word 0x1234 holds 0xBEEF; `a_req`/`a_we`=0 -> OE low in cycles 2–3; `a_ack` in cycle 4; `a_rdata`=0xBEEF; `b_rdata` unchanged.
- Write then read, B (FLASH_WRITE_EN): write 0x5A5A to 0x7FFF -> WE low in cycles 2–3, bus Z in cycle 5, ack in cycle 5; a subsequent read of 0x7FFF returns 0x5A5A.
- Contention: A and B both request reads continuously -> grants alternate A, B, A, B; each ack is separated by 5 cycles with defaults.
- Reset mid-write: assert `rst_n`=0 during WRITE -> WE/CE go high and the bus goes Z immediately; no ack; first grant after release goes to A.
- Wait-state bounds: RD_WAIT=1 -> ack in cycle 3; RD_WAIT=15 -> ack in cycle 17 with OE low for exactly 15 cycles.
- Without FLASH_WRITE_EN: a write of 0x0001 to 0x0000 is acked in cycle 2; WE never low; a subsequent read returns the original contents.

Source files
------------

// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: one requester port of the flash arbiter (level request, one-cycle ack).
interface flash_arbiter_if;
  logic        req;
  logic        we;
  logic [14:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin two-port sequencer for a 32K x 16 asynchronous flash.
// The write path (WRITE/HOLD states, bus drive) is compiled only when FLASH_WRITE_EN is defined.
//
// state | meaning
// IDLE  | strobes high, bus released, arbitrate and latch the winning request
// SETUP | CE low, address settling
// READ  | CE/OE low for RD_WAIT cycles, data captured on the last edge
// WRITE | CE/WE low for WR_WAIT cycles, bus driven
// HOLD  | WE back high, bus still driven for data hold
// DONE  | strobes high, ack to the granted port, round-robin pointer updated
module flash_arbiter #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  flash_arbiter_if.slave port_a,
  flash_arbiter_if.slave port_b,
  output logic [14:0]    flash_address,
  output logic           flash_ce_n,
  output logic           flash_oe_n,
  output logic           flash_we_n,
  inout  wire  [15:0]    flash_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
`ifdef FLASH_WRITE_EN
    WRITE,
    HOLD,
`endif
    DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       gnt_b;
  logic       last_b;
  logic       we_q;
  logic       pick_b;

  // B wins only when A is idle or A had the previous grant.
  assign pick_b = port_b.req && (!port_a.req || !last_b);

`ifdef FLASH_WRITE_EN
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [15:0] wdata_q;
  logic        drive_en;

  assign flash_data = drive_en ? wdata_q : 16'hzzzz;
`else
  localparam int unused_wr_wait = WR_WAIT;

  logic unused_wdata;

  assign unused_wdata = ^{port_a.wdata, port_b.wdata};
  assign flash_we_n   = 1'b1;
  assign flash_data   = 16'hzzzz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      gnt_b         <= 1'b0;
      last_b        <= 1'b1;
      we_q          <= 1'b0;
      flash_address <= '0;
      flash_ce_n    <= 1'b1;
      flash_oe_n    <= 1'b1;
`ifdef FLASH_WRITE_EN
      flash_we_n    <= 1'b1;
      drive_en      <= 1'b0;
      wdata_q       <= '0;
`endif
      port_a.ack    <= 1'b0;
      port_b.ack    <= 1'b0;
      port_a.rdata  <= '0;
      port_b.rdata  <= '0;
    end else begin
      port_a.ack <= 1'b0;
      port_b.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (port_a.req || port_b.req) begin
            gnt_b         <= pick_b;
            flash_address <= pick_b ? port_b.addr : port_a.addr;
            we_q          <= pick_b ? port_b.we : port_a.we;
`ifdef FLASH_WRITE_EN
            wdata_q       <= pick_b ? port_b.wdata : port_a.wdata;
`endif
            flash_ce_n    <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (we_q) begin
`ifdef FLASH_WRITE_EN
            flash_we_n <= 1'b0;
            drive_en   <= 1'b1;
            wait_cnt   <= WR_LOAD;
            state      <= WRITE;
`else
            // No write path: acknowledge without touching the flash.
            flash_ce_n <= 1'b1;
            port_a.ack <= !gnt_b;
            port_b.ack <= gnt_b;
            state      <= DONE;
`endif
          end else begin
            flash_oe_n <= 1'b0;
            wait_cnt   <= RD_LOAD;
            state      <= READ;
          end
        end
        READ: begin
          if (wait_cnt == 4'd0) begin
            if (gnt_b) port_b.rdata <= flash_data;
            else       port_a.rdata <= flash_data;
            flash_oe_n <= 1'b1;
            flash_ce_n <= 1'b1;
            port_a.ack <= !gnt_b;
            port_b.ack <= gnt_b;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`ifdef FLASH_WRITE_EN
        WRITE: begin
          if (wait_cnt == 4'd0) begin
            flash_we_n <= 1'b1;
            state      <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          drive_en   <= 1'b0;
          flash_ce_n <= 1'b1;
          port_a.ack <= !gnt_b;
          port_b.ack <= gnt_b;
          state      <= DONE;
        end
`endif
        DONE: begin
          last_b <= gnt_b;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: randomized scoreboard bench for flash_arbiter with a behavioural flash and reference memory.
module tb_flash_arbiter;

  localparam int RD_W = 2;
  localparam int WR_W = 2;
`ifdef FLASH_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  typedef struct {
    bit          is_read;
    logic [15:0] rdata;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    bit port;
    int cyc;
  } ack_rec_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  flash_arbiter_if ifa ();
  flash_arbiter_if ifb ();
  flash_arbiter_if w1a ();
  flash_arbiter_if w1b ();
  flash_arbiter_if w15a ();
  flash_arbiter_if w15b ();

  logic [14:0] flash_address, w1_addr, w15_addr;
  logic        flash_ce_n, flash_oe_n, flash_we_n;
  logic        w1_ce_n, w1_oe_n, w1_we_n, w15_ce_n, w15_oe_n, w15_we_n;
  wire  [15:0] flash_data;
  wire  [15:0] w1_data;
  wire  [15:0] w15_data;

  flash_arbiter #(.RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
    .clk(clk), .rst_n(rst_n), .port_a(ifa), .port_b(ifb),
    .flash_address(flash_address), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_data(flash_data)
  );

  flash_arbiter #(.RD_WAIT(1), .WR_WAIT(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .port_a(w1a), .port_b(w1b),
    .flash_address(w1_addr), .flash_ce_n(w1_ce_n), .flash_oe_n(w1_oe_n),
    .flash_we_n(w1_we_n), .flash_data(w1_data)
  );

  flash_arbiter #(.RD_WAIT(15), .WR_WAIT(15)) dut_w15 (
    .clk(clk), .rst_n(rst_n), .port_a(w15a), .port_b(w15b),
    .flash_address(w15_addr), .flash_ce_n(w15_ce_n), .flash_oe_n(w15_oe_n),
    .flash_we_n(w15_we_n), .flash_data(w15_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural flash chip for the main instance, plus a fixed-pattern ROM for the wait-state instances.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  function automatic logic [15:0] fpat(input logic [14:0] a);
    return {1'b0, a} ^ 16'h3C5A;
  endfunction

  assign flash_data = (!flash_ce_n && !flash_oe_n) ? mem[flash_address] : 16'hzzzz;
  assign w1_data    = (!w1_ce_n && !w1_oe_n) ? fpat(w1_addr) : 16'hzzzz;
  assign w15_data   = (!w15_ce_n && !w15_oe_n) ? fpat(w15_addr) : 16'hzzzz;

  always @(posedge flash_we_n) begin
    if (rst_n && !flash_ce_n) mem[flash_address] <= flash_data;
  end

  exp_t     qa[$];
  exp_t     qb[$];
  ack_rec_t ack_log[$];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_true(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: condition false, required true (cycle %0d)", name, cyc);
    end
  endtask

  // A released bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  function automatic bit released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  function automatic int lat(input bit we);
    if (!we) return 2 + RD_W;
    return WR_EN ? 3 + WR_W : 2;
  endfunction

  // ---------------- monitor ----------------
  logic [15:0] hold_a, hold_b;
  int          oe_run, we_run;
  bit          ce_p1, ce_p2;

  task automatic check_ack(input bit p);
    exp_t e;
    if ((p ? qb.size() : qa.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack port %0d: ack seen, required none (cycle %0d)", p, cyc);
    end else begin
      e = p ? qb.pop_front() : qa.pop_front();
      if (e.is_read) begin
        if (p) hold_b = e.rdata;
        else   hold_a = e.rdata;
        chk_eq(p ? "b_rdata" : "a_rdata", 32'(p ? ifb.rdata : ifa.rdata), 32'(e.rdata));
      end
      if (e.exp_cyc >= 0) chk_eq(p ? "b_ack_cycle" : "a_ack_cycle", 32'(cyc), 32'(e.exp_cyc));
    end
    ack_log.push_back('{port: p, cyc: cyc});
  endtask

  initial begin
    hold_a = '0; hold_b = '0; oe_run = 0; we_run = 0; ce_p1 = 1'b1; ce_p2 = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_a = '0; hold_b = '0; oe_run = 0; we_run = 0; ce_p1 = 1'b1; ce_p2 = 1'b1;
      end else begin
        if (ifa.ack) check_ack(1'b0);
        if (ifb.ack) check_ack(1'b1);
        chk_eq("a_rdata_hold", 32'(ifa.rdata), 32'(hold_a));
        chk_eq("b_rdata_hold", 32'(ifb.rdata), 32'(hold_b));
        chk_true("oe_we_exclusive", flash_oe_n || flash_we_n);
        if (flash_ce_n) chk_true("bus_released_ce_high", released(flash_data));
        if (!flash_ce_n && ce_p1) chk_true("ce_high_two_cycles", ce_p2);
        ce_p2 = ce_p1;
        ce_p1 = flash_ce_n;
        if (!flash_oe_n) oe_run++;
        else if (oe_run != 0) begin
          chk_eq("oe_width", 32'(oe_run), 32'(RD_W));
          oe_run = 0;
        end
`ifdef FLASH_WRITE_EN
        if (!flash_we_n) we_run++;
        else if (we_run != 0) begin
          chk_eq("we_width", 32'(we_run), 32'(WR_W));
          we_run = 0;
        end
`else
        chk_true("we_tied_high", flash_we_n);
        if (flash_oe_n) chk_true("bus_never_driven", released(flash_data));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the edge that ends DONE.
  task automatic do_txn(input bit p, input bit we, input logic [14:0] addr, input logic [15:0] wdata,
                        input int exp_lat, input bit keep_req);
    exp_t e;
    bit   seen;
    seen      = 1'b0;
    e.is_read = !we;
    e.rdata   = ref_mem[addr];
    e.exp_cyc = (exp_lat < 0) ? -1 : cyc + exp_lat;
    if (we && WR_EN) ref_mem[addr] = wdata;
    if (p) begin
      ifb.we = we; ifb.addr = addr; ifb.wdata = wdata; ifb.req = 1'b1;
      qb.push_back(e);
    end else begin
      ifa.we = we; ifa.addr = addr; ifa.wdata = wdata; ifa.req = 1'b1;
      qa.push_back(e);
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (p ? ifb.ack : ifa.ack) begin
        seen = 1'b1;
        break;
      end
      // Once granted, requester-side changes must not leak into the transaction.
      if (exp_lat >= 0 && n == 2) begin
        if (p) begin ifb.addr = 15'($urandom); ifb.wdata = 16'($urandom); end
        else   begin ifa.addr = 15'($urandom); ifa.wdata = 16'($urandom); end
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout port %0d: no ack in 300 cycles, required one", p);
    end
    @(posedge clk);
    #1;
    if (!keep_req) begin
      if (p) ifb.req = 1'b0;
      else   ifa.req = 1'b0;
    end
  endtask

  task automatic rand_port(input bit p, input int count);
    int gap;
    for (int i = 0; i < count; i++) begin
      gap = $urandom_range(0, 3);
      do_txn(p, 1'($urandom_range(0, 1)), {p, 14'($urandom)}, 16'($urandom), -1,
             (gap == 0) && (i != count - 1));
      if (gap != 0) idle(gap);
    end
  endtask

  initial begin
    int t0;
    bit got1, got15, seen;
    int oe1, oe15;

    clk = 1'b0;
    rst_n = 1'b1;
    ifa.req = 0; ifa.we = 0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 0; ifb.we = 0; ifb.addr = '0; ifb.wdata = '0;
    w1a.req = 0; w1a.we = 0; w1a.addr = '0; w1a.wdata = '0;
    w1b.req = 0; w1b.we = 0; w1b.addr = '0; w1b.wdata = '0;
    w15a.req = 0; w15a.we = 0; w15a.addr = '0; w15a.wdata = '0;
    w15b.req = 0; w15b.we = 0; w15b.addr = '0; w15b.wdata = '0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'((i * 40503) ^ 23100);
      ref_mem[i] = 16'((i * 40503) ^ 23100);
    end
    mem[15'h1234]     = 16'hBEEF;
    ref_mem[15'h1234] = 16'hBEEF;

    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_ce_n", 32'(flash_ce_n), 32'd1);
    chk_eq("rst_oe_n", 32'(flash_oe_n), 32'd1);
    chk_eq("rst_we_n", 32'(flash_we_n), 32'd1);
    chk_eq("rst_address", 32'(flash_address), 32'd0);
    chk_eq("rst_acks", 32'({ifa.ack, ifb.ack}), 32'd0);
    chk_eq("rst_a_rdata", 32'(ifa.rdata), 32'd0);
    chk_eq("rst_b_rdata", 32'(ifb.rdata), 32'd0);
    chk_true("rst_bus_released", released(flash_data));
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Directed: single read, write/read-back, write then read on the same word.
    do_txn(1'b0, 1'b0, 15'h1234, 16'h0000, lat(1'b0), 1'b0); idle(2);
    do_txn(1'b1, 1'b1, 15'h7FFF, 16'h5A5A, lat(1'b1), 1'b0); idle(2);
    do_txn(1'b1, 1'b0, 15'h7FFF, 16'h0000, lat(1'b0), 1'b0); idle(2);
    do_txn(1'b0, 1'b1, 15'h0000, 16'h0001, lat(1'b1), 1'b0); idle(2);
    do_txn(1'b0, 1'b0, 15'h0000, 16'h0000, lat(1'b0), 1'b0); idle(2);

    // Contention: both ports stream reads back-to-back.
    ack_log.delete();
    fork
      for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b0, {1'b0, 14'($urandom)}, 16'h0, -1, i != 3);
      for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b0, {1'b1, 14'($urandom)}, 16'h0, -1, i != 3);
    join
    idle(2);
    chk_eq("contention_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 1; i < ack_log.size(); i++) begin
      chk_true("contention_alternate", ack_log[i].port != ack_log[i-1].port);
      chk_eq("contention_spacing", 32'(ack_log[i].cyc - ack_log[i-1].cyc), 32'(RD_W + 3));
    end

    // Random mixed traffic; each port owns half the address space.
    fork
      rand_port(1'b0, 30);
      rand_port(1'b1, 30);
    join
    idle(3);

    // Reset in the middle of a transaction.
    ifa.we = WR_EN; ifa.addr = 15'h0100; ifa.wdata = 16'hA5A5; ifa.req = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (WR_EN ? !flash_we_n : !flash_oe_n) begin
        seen = 1'b1;
        break;
      end
    end
    chk_true("abort_strobe_seen", seen);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("abort_ce_n", 32'(flash_ce_n), 32'd1);
    chk_eq("abort_oe_n", 32'(flash_oe_n), 32'd1);
    chk_eq("abort_we_n", 32'(flash_we_n), 32'd1);
    chk_true("abort_bus_released", released(flash_data));
    ifa.req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_eq("abort_no_ack", 32'({ifa.ack, ifb.ack}), 32'd0);
    end
    #1 rst_n = 1'b1;
    idle(2);
    ack_log.delete();
    fork
      do_txn(1'b0, 1'b0, 15'h0200, 16'h0, -1, 1'b0);
      do_txn(1'b1, 1'b0, 15'h4200, 16'h0, -1, 1'b0);
    join
    chk_eq("first_grant_after_reset", 32'(ack_log.size() > 0 ? ack_log[0].port : 1'b1), 32'd0);
    idle(2);

    // Wait-state bounds on the RD_WAIT=1 and RD_WAIT=15 instances.
    w1a.addr = 15'h0ABC; w15a.addr = 15'h0ABC; w1a.req = 1'b1; w15a.req = 1'b1;
    t0 = cyc; got1 = 1'b0; got15 = 1'b0; oe1 = 0; oe15 = 0;
    for (int n = 0; n < 40 && !(got1 && got15); n++) begin
      @(negedge clk);
      if (!w1_oe_n) oe1++;
      if (!w15_oe_n) oe15++;
      if (w1a.ack && !got1) begin
        got1 = 1'b1;
        chk_eq("w1_ack_cycle", 32'(cyc), 32'(t0 + 3));
        chk_eq("w1_rdata", 32'(w1a.rdata), 32'(fpat(15'h0ABC)));
        w1a.req = 1'b0;
      end
      if (w15a.ack && !got15) begin
        got15 = 1'b1;
        chk_eq("w15_ack_cycle", 32'(cyc), 32'(t0 + 17));
        chk_eq("w15_rdata", 32'(w15a.rdata), 32'(fpat(15'h0ABC)));
        w15a.req = 1'b0;
      end
    end
    chk_true("w1_ack_seen", got1);
    chk_true("w15_ack_seen", got15);
    chk_eq("w1_oe_width", 32'(oe1), 32'd1);
    chk_eq("w15_oe_width", 32'(oe15), 32'd15);

    idle(3);
    chk_eq("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
